// File: rtl/spm_multiplier_pkg.sv
// Shared constants for the serial-parallel multiplier slice.
// Holds the default multiplicand width and the reset-active level.
// Imported by the interface, the cell and the top.
package spm_multiplier_pkg;

    // Default width of the parallel multiplicand X.
    localparam int DEFAULT_WIDTH = 32;

    // RST is asserted when it is at this level.
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/spm_multiplier_if.sv
// Bus bundle for the serial-parallel multiplier.
// The master drives the multiplicand X and the serial multiplier Y.
// The slave returns the serial product P.
interface spm_multiplier_if
    import spm_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] X;    // multiplicand, held stable for a whole operation
    logic             Y;    // multiplier bit stream, LSB first
    logic             P;    // product bit stream, LSB first

    modport master (
        output X,
        output Y,
        input  P
    );

    modport slave (
        input  X,
        input  Y,
        output P
    );

endinterface

// File: rtl/spm_multiplier_cell.sv
// One carry-save cell: partial-product AND, full adder, sum and carry flops.
// Latency: one cycle from inputs to s_out.
// Backpressure: none; the cell consumes a bit on every clock.
module spm_cell
    import spm_multiplier_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic x_bit,     // multiplicand bit X[i]
    input  logic y_bit,     // current multiplier bit
    input  logic s_in,      // sum from the next-higher cell, s[i+1]
    output logic s_out      // this cell's sum flop, s[i]
);

    logic c_q;
    logic pp;
    logic fa_sum;
    logic fa_carry;

    // Partial product and full adder. The carry stays local to the cell,
    // so there is no ripple path between cells.
    assign pp       = x_bit & y_bit;
    assign fa_sum   = pp ^ s_in ^ c_q;
    assign fa_carry = (pp & s_in) | (pp & c_q) | (s_in & c_q);

    // Sum and carry state. Reset clears both immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (RST == RST_ACTIVE) begin
            s_out <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            s_out <= fa_sum;
            c_q   <= fa_carry;
        end
    end

endmodule

// File: rtl/spm_multiplier.sv
// Unsigned serial-parallel multiplier: parallel X times serial Y, serial P out.
// Latency: one cycle; P bit k is valid after the edge that samples Y bit k.
// Backpressure: none; the caller frames M multiplier bits plus WIDTH zeros.
module spm_multiplier
    import spm_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic             CLK,
    input  logic             RST,
    spm_multiplier_if.slave  bus
);

    // s[i] is the sum flop of cell i; s[WIDTH] feeds zeros into the top cell
    // so the array drains to all-zero after WIDTH cycles of Y=0.
    logic [WIDTH:0] s;

    assign s[WIDTH] = 1'b0;

    // WIDTH identical cells, each taking its sum input from the cell above.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        spm_cell u_cell (
            .CLK   (CLK),
            .RST   (RST),
            .x_bit (bus.X[i]),
            .y_bit (bus.Y),
            .s_in  (s[i+1]),
            .s_out (s[i])
        );
    end

    // The product bit is the lowest sum flop: registered, no path from X or Y.
    assign bus.P = s[0];

endmodule

// File: tb/tb_spm_multiplier.sv
// Self-checking bench for spm_multiplier.
// Expected product bits come from plain X*Y arithmetic on 64-bit values.
// Directed cases pin the model with hand-computed products.
module tb_spm_multiplier;
    import spm_multiplier_pkg::*;

    localparam int W = 32;

    logic CLK;
    logic RST;

    spm_multiplier_if #(.WIDTH(W)) bus ();

    spm_multiplier #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
        end
    endtask

    // Runs one framed operation starting at a falling edge: M multiplier bits
    // then W zeros. Every product bit is compared at the falling edge after
    // the rising edge that sampled the matching Y bit, then the collected
    // bits are compared against a literal (directed) or the model (random).
    task automatic run_op(input logic [W-1:0] x, input logic [31:0] y, input int m,
                          input logic [63:0] lit, input bit use_lit, input string name);
        logic [63:0] ym;
        logic [63:0] prod;
        logic [63:0] got;
        if (m >= 32) ym = {32'b0, y};
        else         ym = {32'b0, y} & ((64'd1 << m) - 64'd1);
        prod = {32'b0, x} * ym;
        got  = '0;
        bus.X = x;
        for (int k = 0; k < m + W; k++) begin
            bus.Y = ym[k];
            @(posedge CLK);
            @(negedge CLK);
            got[k] = bus.P;
            check({name, " bit"}, 64'(bus.P), 64'(prod[k]));
        end
        bus.Y = 1'b0;
        if (use_lit) check({name, " literal"}, got, lit);
        else         check({name, " product"}, got, prod);
    endtask

    initial begin
        logic [31:0] y16;
        logic [63:0] t;

        RST   = 1'b1;
        bus.X = '0;
        bus.Y = 1'b0;
        #1 RST = 1'b0;

        // Held in reset with inputs toggling: P must stay 0.
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            bus.X = $urandom;
            bus.Y = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1 check("reset hold", 64'(bus.P), 64'd0);
        end

        // Release between edges; the next rising edge samples Y bit 0.
        @(negedge CLK);
        RST   = 1'b1;
        bus.Y = 1'b0;

        run_op(32'd4, 32'd1, 1, 64'd4, 1'b1, "x4 y1");
        run_op(32'd3, 32'd3, 2, 64'd9, 1'b1, "x3 y3");
        run_op(32'd5, 32'd5, 3, 64'd25, 1'b1, "x5 y5 back-to-back");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 64'hFFFF_FFFE_0000_0001, 1'b1, "all ones");
        run_op(32'($urandom), 32'd0, 32, 64'd0, 1'b1, "y zero");

        // X changed mid-operation, then W cycles of Y=0 with X held: the
        // array must drain so the next operation is exact.
        for (int i = 0; i < 10; i++) begin
            bus.X = $urandom;
            bus.Y = 1'($urandom_range(0, 1));
            @(posedge CLK);
            @(negedge CLK);
        end
        bus.X = $urandom;
        bus.Y = 1'b0;
        repeat (W) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        run_op(32'd3, 32'd3, 2, 64'd9, 1'b1, "after x change");

        // Mid-operation reset. Pick Y bits so that product bit 15 is 1,
        // making the asynchronous clear visible on P.
        y16 = 32'($urandom_range(0, 65535));
        for (int i = 0; i < 64; i++) begin
            t = 64'hDEAD_BEEF * {32'b0, y16};
            if (t[15]) break;
            y16 = 32'($urandom_range(0, 65535));
        end
        t = 64'hDEAD_BEEF * {32'b0, y16};
        bus.X = 32'hDEAD_BEEF;
        for (int k = 0; k < 16; k++) begin
            bus.Y = y16[k];
            @(posedge CLK);
            @(negedge CLK);
            check("mid-op bit", 64'(bus.P), 64'(t[k]));
        end
        #1 RST = 1'b0;
        #1 check("async clear", 64'(bus.P), 64'd0);
        bus.Y = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            @(negedge CLK);
            check("mid-op reset hold", 64'(bus.P), 64'd0);
        end
        RST   = 1'b1;
        bus.Y = 1'b0;
        run_op(32'd7, 32'd6, 3, 64'd42, 1'b1, "after reset");

        // Random regression against the arithmetic model.
        for (int n = 0; n < 1000; n++) begin
            run_op(32'($urandom), 32'($urandom), $urandom_range(1, 32), 64'd0, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
